// File: rtl/rally_sequencer.sv
// rally_sequencer: game-level phase controller sitting above the ball motion
// engine. Sequences IDLE -> SERVE -> RALLY -> POINT -> (SERVE | GAME_OVER),
// tracks lives, score and best score, and drives the engine restart pulse,
// run enable and the speed command latched on each accepted paddle hit.
module rally_sequencer #(
    parameter int unsigned SERVE_DELAY = 25_000_000,
    parameter int unsigned POINT_DELAY = 12_500_000,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned MISS_X      = 4,
    parameter int unsigned SPEED_MAX   = 16
) (
    input  logic        clk_25MHZ,
    input  logic        reset,
    input  logic        start_btn,
    input  logic [9:0]  ball_x,
    input  logic        is_ball_moving_left,
    input  logic        collision_detected,
    input  logic [9:0]  estimated_speed,
    output logic        ball_restart,
    output logic        game_run,
    output logic [9:0]  speed_cmd,
    output logic [3:0]  lives,
    output logic [15:0] score,
    output logic [15:0] best_score,
    output logic        game_over,
    output logic [2:0]  phase
);

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_SERVE     = 3'd1,
        PH_RALLY     = 3'd2,
        PH_POINT     = 3'd3,
        PH_GAME_OVER = 3'd4
    } phase_e;

    localparam logic [24:0] SERVE_LOAD  = 25'(SERVE_DELAY - 1);
    localparam logic [24:0] POINT_LOAD  = 25'(POINT_DELAY - 1);
    localparam logic [3:0]  LIVES_INIT  = 4'(LIVES);
    localparam logic [9:0]  MISS_X_L    = 10'(MISS_X);
    localparam logic [9:0]  SPEED_MAX_L = 10'(SPEED_MAX);

    // Clamp the paddle speed estimate into 1..SPEED_MAX (0 maps to 1).
    function automatic logic [9:0] clamp_speed(input logic [9:0] est);
        logic [9:0] r;
        if (est < 10'd1) begin
            r = 10'd1;
        end else if (est > SPEED_MAX_L) begin
            r = SPEED_MAX_L;
        end else begin
            r = est;
        end
        return r;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    phase_e      phase_q,        phase_d;
    logic [24:0] cnt_q,          cnt_d;
    logic        hit_armed_q,    hit_armed_d;
    logic        start_prev_q,   start_prev_d;
    logic        ball_restart_q, ball_restart_d;
    logic        game_run_q,     game_run_d;
    logic [9:0]  speed_cmd_q,    speed_cmd_d;
    logic [3:0]  lives_q,        lives_d;
    logic [15:0] score_q,        score_d;
    logic [15:0] best_score_q,   best_score_d;
    logic        game_over_q,    game_over_d;

    logic start_rise;
    logic hit;
    logic miss;

    // Event decode: button edge, accepted paddle hit, and ball lost past the paddle.
    always_comb begin
        start_rise = start_btn & ~start_prev_q;
        hit        = collision_detected & is_ball_moving_left & hit_armed_q;
        miss       = is_ball_moving_left & (ball_x <= MISS_X_L) & hit_armed_q
                     & (lives_q != 4'd0);
    end

    // Next-state and next-output computation for the game phase machine.
    always_comb begin
        phase_d        = phase_q;
        cnt_d          = cnt_q;
        start_prev_d   = start_btn;
        ball_restart_d = 1'b0;
        speed_cmd_d    = speed_cmd_q;
        lives_d        = lives_q;
        score_d        = score_q;
        best_score_d   = best_score_q;

        // The ball travelling right re-arms hit detection for the next return.
        if (!is_ball_moving_left) begin
            hit_armed_d = 1'b1;
        end else begin
            hit_armed_d = hit_armed_q;
        end

        case (phase_q)
            PH_IDLE: begin
                if (start_rise) begin
                    phase_d        = PH_SERVE;
                    cnt_d          = SERVE_LOAD;
                    ball_restart_d = 1'b1;
                    speed_cmd_d    = 10'd1;
                    hit_armed_d    = 1'b1;
                    lives_d        = LIVES_INIT;
                    score_d        = 16'd0;
                end else begin
                    phase_d = PH_IDLE;
                end
            end

            PH_SERVE: begin
                if (cnt_q == 25'd0) begin
                    phase_d = PH_RALLY;
                end else begin
                    cnt_d = cnt_q - 25'd1;
                end
            end

            PH_RALLY: begin
                // A hit takes priority over a simultaneous miss.
                if (hit) begin
                    score_d     = sat_inc16(score_q);
                    speed_cmd_d = clamp_speed(estimated_speed);
                    hit_armed_d = 1'b0;
                end else if (miss) begin
                    lives_d = lives_q - 4'd1;
                    phase_d = PH_POINT;
                    cnt_d   = POINT_LOAD;
                end else begin
                    phase_d = PH_RALLY;
                end
            end

            PH_POINT: begin
                if (cnt_q == 25'd0) begin
                    if (lives_q == 4'd0) begin
                        phase_d = PH_GAME_OVER;
                        if (score_q > best_score_q) begin
                            best_score_d = score_q;
                        end else begin
                            best_score_d = best_score_q;
                        end
                    end else begin
                        phase_d        = PH_SERVE;
                        cnt_d          = SERVE_LOAD;
                        ball_restart_d = 1'b1;
                        speed_cmd_d    = 10'd1;
                        hit_armed_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 25'd1;
                end
            end

            PH_GAME_OVER: begin
                if (start_rise) begin
                    phase_d        = PH_SERVE;
                    cnt_d          = SERVE_LOAD;
                    ball_restart_d = 1'b1;
                    speed_cmd_d    = 10'd1;
                    hit_armed_d    = 1'b1;
                    lives_d        = LIVES_INIT;
                    score_d        = 16'd0;
                end else begin
                    phase_d = PH_GAME_OVER;
                end
            end

            default: begin
                phase_d = PH_IDLE;
                cnt_d   = 25'd0;
            end
        endcase

        // Engine enable and game-over flag follow the phase being entered.
        game_run_d  = (phase_d == PH_RALLY);
        game_over_d = (phase_d == PH_GAME_OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            phase_q        <= PH_IDLE;
            cnt_q          <= 25'd0;
            hit_armed_q    <= 1'b1;
            start_prev_q   <= 1'b1;
            ball_restart_q <= 1'b0;
            game_run_q     <= 1'b0;
            speed_cmd_q    <= 10'd1;
            lives_q        <= LIVES_INIT;
            score_q        <= 16'd0;
            best_score_q   <= 16'd0;
            game_over_q    <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            hit_armed_q    <= hit_armed_d;
            start_prev_q   <= start_prev_d;
            ball_restart_q <= ball_restart_d;
            game_run_q     <= game_run_d;
            speed_cmd_q    <= speed_cmd_d;
            lives_q        <= lives_d;
            score_q        <= score_d;
            best_score_q   <= best_score_d;
            game_over_q    <= game_over_d;
        end
    end

    assign ball_restart = ball_restart_q;
    assign game_run     = game_run_q;
    assign speed_cmd    = speed_cmd_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign best_score   = best_score_q;
    assign game_over    = game_over_q;
    assign phase        = phase_q;

endmodule

// File: tb/tb_rally_sequencer.sv
// Directed bench for rally_sequencer with small delays. Each step drives the
// inputs, queues the state the DUT should show after the next clock edge, and
// compares the popped expectation against the outputs on the falling edge.
module tb_rally_sequencer;

    logic        clk;
    logic        reset;
    logic        start_btn;
    logic [9:0]  ball_x;
    logic        left;
    logic        coll;
    logic [9:0]  est;
    logic        ball_restart;
    logic        game_run;
    logic [9:0]  speed_cmd;
    logic [3:0]  lives;
    logic [15:0] score;
    logic [15:0] best_score;
    logic        game_over;
    logic [2:0]  phase;

    typedef struct packed {
        logic [2:0]  phase;
        logic        restart;
        logic        run;
        logic [9:0]  speed;
        logic [3:0]  lives;
        logic [15:0] score;
        logic [15:0] best;
        logic        over;
    } snap_t;

    snap_t obs;
    snap_t e;
    snap_t exp_q[$];
    string tag_q[$];
    int    n_total;
    int    n_pass;
    int    n_fail;

    rally_sequencer #(
        .SERVE_DELAY(4),
        .POINT_DELAY(3),
        .LIVES(2),
        .MISS_X(4),
        .SPEED_MAX(16)
    ) dut (
        .clk_25MHZ(clk),
        .reset(reset),
        .start_btn(start_btn),
        .ball_x(ball_x),
        .is_ball_moving_left(left),
        .collision_detected(coll),
        .estimated_speed(est),
        .ball_restart(ball_restart),
        .game_run(game_run),
        .speed_cmd(speed_cmd),
        .lives(lives),
        .score(score),
        .best_score(best_score),
        .game_over(game_over),
        .phase(phase)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    assign obs = {phase, ball_restart, game_run, speed_cmd, lives, score, best_score, game_over};

    // Queue the expectation, clock once, then pop and compare on the falling edge.
    task automatic cyc(input string tag);
        snap_t want;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        e.restart = 1'b0;
        @(posedge clk);
        @(negedge clk);
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        n_total++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed ph=%0d rs=%0d run=%0d spd=%0d lives=%0d score=%0d best=%0d over=%0d expected ph=%0d rs=%0d run=%0d spd=%0d lives=%0d score=%0d best=%0d over=%0d",
                   t, obs.phase, obs.restart, obs.run, obs.speed, obs.lives, obs.score, obs.best, obs.over,
                   want.phase, want.restart, want.run, want.speed, want.lives, want.score, want.best, want.over);
        end
    endtask

    // Remaining three SERVE cycles followed by entry into RALLY.
    task automatic serve_to_rally();
        for (int i = 0; i < 3; i++) cyc("serve_wait");
        e.phase = 3'd2;
        e.run   = 1'b1;
        cyc("rally_enter");
    endtask

    task automatic set_reset_values();
        e = '{phase: 3'd0, restart: 1'b0, run: 1'b0, speed: 10'd1, lives: 4'd2,
              score: 16'd0, best: 16'd0, over: 1'b0};
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        reset     = 1'b1;
        start_btn = 1'b1;
        ball_x    = 10'd300;
        left      = 1'b0;
        coll      = 1'b0;
        est       = 10'd0;
        set_reset_values();
        cyc("reset_state");

        // Button held through reset must not start a game.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cyc("held_idle");
        start_btn = 1'b0;
        cyc("released_idle");

        start_btn = 1'b1;
        e.phase   = 3'd1;
        e.restart = 1'b1;
        cyc("serve_enter");
        serve_to_rally();

        // Sustained collision counts once.
        left = 1'b1; coll = 1'b1; est = 10'd40;
        e.score = 16'd1; e.speed = 10'd16;
        for (int i = 0; i < 5; i++) cyc("single_hit");
        left = 1'b0; coll = 1'b0;
        cyc("rearm");
        left = 1'b1; coll = 1'b1; est = 10'd0;
        e.score = 16'd2; e.speed = 10'd1;
        cyc("hit_speed_zero");
        left = 1'b0; coll = 1'b0;
        cyc("rearm2");

        // First miss at the boundary ball_x == MISS_X.
        left = 1'b1; ball_x = 10'd4;
        e.lives = 4'd1; e.phase = 3'd3; e.run = 1'b0;
        cyc("miss1");
        left = 1'b0; ball_x = 10'd300;
        for (int i = 0; i < 2; i++) cyc("point_wait");
        e.phase = 3'd1; e.restart = 1'b1;
        cyc("point_to_serve");
        serve_to_rally();

        // Hit and miss together: hit wins.
        left = 1'b1; coll = 1'b1; ball_x = 10'd3; est = 10'd5;
        e.score = 16'd3; e.speed = 10'd5;
        cyc("hit_beats_miss");
        left = 1'b0; coll = 1'b0; ball_x = 10'd300;
        cyc("rearm3");

        for (int i = 0; i < 4; i++) begin
            left = 1'b1; coll = 1'b1; est = 10'd7;
            e.score = e.score + 16'd1; e.speed = 10'd7;
            cyc("build_score");
            left = 1'b0; coll = 1'b0;
            cyc("rearm_loop");
        end

        // Last life lost: game over with best score captured.
        left = 1'b1; ball_x = 10'd2;
        e.lives = 4'd0; e.phase = 3'd3; e.run = 1'b0;
        cyc("miss2");
        left = 1'b0; ball_x = 10'd300;
        for (int i = 0; i < 2; i++) cyc("point_wait2");
        e.phase = 3'd4; e.over = 1'b1; e.best = 16'd7;
        cyc("game_over");
        start_btn = 1'b0;
        cyc("game_over_hold");
        start_btn = 1'b1;
        e.phase = 3'd1; e.restart = 1'b1; e.lives = 4'd2; e.score = 16'd0;
        e.over = 1'b0; e.speed = 10'd1;
        cyc("new_game");
        serve_to_rally();

        // Reset during RALLY.
        left = 1'b1; coll = 1'b1; est = 10'd9;
        e.score = 16'd1; e.speed = 10'd9;
        cyc("hit_before_reset");
        reset = 1'b1;
        set_reset_values();
        cyc("reset_in_rally");
        reset = 1'b0; left = 1'b0; coll = 1'b0;
        cyc("idle_after_reset");

        // Reset during POINT.
        start_btn = 1'b0;
        cyc("idle_release");
        start_btn = 1'b1;
        e.phase = 3'd1; e.restart = 1'b1;
        cyc("serve_again");
        serve_to_rally();
        left = 1'b1; ball_x = 10'd1;
        e.lives = 4'd1; e.phase = 3'd3; e.run = 1'b0;
        cyc("miss3");
        reset = 1'b1; left = 1'b0; ball_x = 10'd300;
        set_reset_values();
        cyc("reset_in_point");
        reset = 1'b0;
        cyc("idle_final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
